// File: rtl/alu_result_stage_if.sv
// Handshake/result bundle between the adder/subtractor and its registered output stage.
// master drives the upstream beat and the downstream ready; slave is the stage itself.
interface alu_result_stage_if #(
    parameter int DATAW = 2,
    parameter int CNTW  = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [DATAW:0]   i_result;
    logic             i_sat;
    logic             o_valid;
    logic             i_ready;
    logic [DATAW-1:0] o_data;
    logic             o_zero;
    logic             o_neg;
    logic             o_ovf;
    logic             i_clr;
    logic [CNTW-1:0]  o_ovf_cnt;

    modport master (
        output i_valid, i_result, i_sat, i_ready, i_clr,
        input  o_ready, o_valid, o_data, o_zero, o_neg, o_ovf, o_ovf_cnt
    );
    modport slave (
        input  i_valid, i_result, i_sat, i_ready, i_clr,
        output o_ready, o_valid, o_data, o_zero, o_neg, o_ovf, o_ovf_cnt
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered result stage: wrap/saturate the (DATAW+1)-bit exact result to DATAW bits,
// derive flags, buffer through a 2-entry skid buffer and count overflowing beats.
module alu_result_stage #(
    parameter int DATAW = 2,
    parameter int CNTW  = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    alu_result_stage_if.slave bus
);
    typedef struct packed {
        logic [DATAW-1:0] data;
        logic             zero;
        logic             neg;
        logic             ovf;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t          state;
    entry_t          main_q, skid_q, in_e;
    logic            vld_q, rdy_q;
    logic [CNTW-1:0] cnt_q;
    logic            accept, xfer;

    // Format the incoming beat once; both buffer slots store the finished result.
    always_comb begin
        in_e      = '0;
        in_e.ovf  = bus.i_result[DATAW] ^ bus.i_result[DATAW-1];
        in_e.neg  = bus.i_result[DATAW];
        if (in_e.ovf && bus.i_sat)
            in_e.data = in_e.neg ? {1'b1, {(DATAW-1){1'b0}}} : {1'b0, {(DATAW-1){1'b1}}};
        else
            in_e.data = bus.i_result[DATAW-1:0];
        in_e.zero = (in_e.data == '0);
    end

    assign accept = bus.i_valid && rdy_q;
    assign xfer   = vld_q && bus.i_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= EMPTY;
            vld_q  <= 1'b0;
            rdy_q  <= 1'b1;
            main_q <= '0;
            skid_q <= '0;
            cnt_q  <= '0;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    main_q <= in_e;
                    state  <= ONE;
                    vld_q  <= 1'b1;
                end
                ONE: begin
                    if (accept && xfer) begin
                        main_q <= in_e;
                    end else if (accept) begin
                        skid_q <= in_e;
                        state  <= FULL;
                        rdy_q  <= 1'b0;
                    end else if (xfer) begin
                        state  <= EMPTY;
                        vld_q  <= 1'b0;
                    end
                end
                FULL: if (xfer) begin
                    main_q <= skid_q;
                    skid_q <= '0;
                    state  <= ONE;
                    rdy_q  <= 1'b1;
                end
                default: begin
                    state <= EMPTY;
                    vld_q <= 1'b0;
                    rdy_q <= 1'b1;
                end
            endcase

            // Clear wins over a coincident overflow; count sticks at all-ones.
            if (bus.i_clr)
                cnt_q <= '0;
            else if (accept && in_e.ovf && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.o_valid   = vld_q;
    assign bus.o_ready   = rdy_q;
    assign bus.o_data    = main_q.data;
    assign bus.o_zero    = main_q.zero;
    assign bus.o_neg     = main_q.neg;
    assign bus.o_ovf     = main_q.ovf;
    assign bus.o_ovf_cnt = cnt_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage (DATAW=4, CNTW=2): directed test-plan cases
// followed by randomized traffic against an arithmetic reference model.
module tb_alu_result_stage;
    localparam int DATAW = 4;
    localparam int CNTW  = 2;
    localparam int CMAX  = 3;

    typedef struct {
        int data;
        bit zero;
        bit neg;
        bit ovf;
    } exp_t;

    logic clk = 0;
    logic rst_n = 0;
    bit   started = 0;
    int   checks = 0;
    int   errors = 0;
    int   mcnt = 0;
    exp_t sb[$];

    alu_result_stage_if #(.DATAW(DATAW), .CNTW(CNTW)) bus();

    alu_result_stage #(.DATAW(DATAW), .CNTW(CNTW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: interpret the result as a signed integer and apply the range rules.
    function automatic exp_t model(input logic [DATAW:0] r, input logic sat);
        exp_t e;
        int v, d;
        v = int'(r);
        if (v > 15) v -= 32;
        e.ovf = (v > 7) || (v < -8);
        e.neg = (v < 0);
        d = (sat && e.ovf) ? (e.neg ? -8 : 7) : v;
        e.data = d & 15;
        e.zero = (e.data == 0);
        return e;
    endfunction

    // Monitor: check occupancy/outputs against the model, then retire and record beats.
    always @(negedge clk) begin
        exp_t e;
        logic [DATAW-1:0] d;
        if (started) begin
            chk("o_valid", bus.o_valid, sb.size() > 0);
            chk("o_ready", bus.o_ready, sb.size() < 2);
            chk("o_ovf_cnt", bus.o_ovf_cnt, mcnt);
            if (bus.o_valid && sb.size() > 0) begin
                d = sb[0].data[DATAW-1:0];
                chk("o_data", bus.o_data, d);
                chk("o_zero", bus.o_zero, sb[0].zero);
                chk("o_neg",  bus.o_neg,  sb[0].neg);
                chk("o_ovf",  bus.o_ovf,  sb[0].ovf);
            end
            if (!rst_n) begin
                sb.delete();
                mcnt = 0;
            end else begin
                if (bus.o_valid && bus.i_ready && sb.size() > 0) void'(sb.pop_front());
                e = model(bus.i_result, bus.i_sat);
                if (bus.i_valid && bus.o_ready) sb.push_back(e);
                if (bus.i_clr) mcnt = 0;
                else if (bus.i_valid && bus.o_ready && e.ovf && mcnt < CMAX) mcnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc();
        bit a;
        a = 0;
        for (int k = 0; k < 50 && !a; k++) begin
            @(negedge clk);
            a = bus.o_ready;
            tick();
        end
        if (!a) chk("accept_timeout", 0, 1);
    endtask

    task automatic send(input logic [DATAW:0] r, input logic s);
        bus.i_valid  = 1;
        bus.i_result = r;
        bus.i_sat    = s;
        wait_acc();
    endtask

    task automatic idle(input int n);
        bus.i_valid = 0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        started = 1;
    endtask

    task automatic chk_reset_state();
        chk("rst_o_valid", bus.o_valid, 0);
        chk("rst_o_ready", bus.o_ready, 1);
        chk("rst_o_data",  bus.o_data, 0);
        chk("rst_o_zero",  bus.o_zero, 0);
        chk("rst_o_neg",   bus.o_neg, 0);
        chk("rst_o_ovf",   bus.o_ovf, 0);
        chk("rst_o_ovf_cnt", bus.o_ovf_cnt, 0);
    endtask

    initial begin
        bus.i_valid = 0; bus.i_result = '0; bus.i_sat = 0; bus.i_ready = 1; bus.i_clr = 0;
        do_reset();
        chk_reset_state();

        // Wrap / saturate / flag cases, streaming with i_ready=1.
        send(5'b00101, 0);
        send(5'b01000, 0);
        send(5'b01000, 1);
        send(5'b10111, 1);
        send(5'b10111, 0);
        send(5'b00000, 0);
        idle(3);

        // Backpressure: A,B fill the buffer, C waits, then drain in order.
        bus.i_ready = 0;
        send(5'd1, 0);
        send(5'd2, 0);
        bus.i_result = 5'd3;
        repeat (3) tick();
        chk("bp_ready_low", bus.o_ready, 0);
        chk("bp_hold_data", bus.o_data, 1);
        bus.i_ready = 1;
        wait_acc();
        idle(4);

        // Counter saturation at CNTW=2, then clear beating a coincident overflow.
        do_reset();
        repeat (5) send(5'b01000, 0);
        chk("cnt_sat", bus.o_ovf_cnt, 3);
        bus.i_clr = 1;
        send(5'b01000, 0);
        bus.i_clr = 0;
        idle(1);
        chk("cnt_clr", bus.o_ovf_cnt, 0);
        idle(3);

        // Reset while FULL and stalled; the next beat must come out alone.
        bus.i_ready = 0;
        send(5'd9, 1);
        send(5'd10, 0);
        bus.i_valid = 0;
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        chk_reset_state();
        bus.i_ready = 1;
        send(5'b00011, 0);
        idle(4);

        // Randomized traffic with random backpressure and occasional clears.
        for (int i = 0; i < 600; i++) begin
            bus.i_valid  = ($urandom % 4) != 0;
            bus.i_result = 5'($urandom);
            bus.i_sat    = 1'($urandom);
            bus.i_ready  = ($urandom % 3) != 0;
            bus.i_clr    = ($urandom % 40) == 0;
            tick();
        end
        bus.i_clr = 0;
        bus.i_ready = 1;
        idle(6);
        chk("drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the adder/subtractor.
- Consumes its (DATAW+1)-bit sign-extended two's-complement result and produces an N-bit result with optional saturation, plus zero, negative and overflow flags.
- Uses a valid/ready handshake with a 2-entry skid buffer, so throughput is one result per cycle and o_ready is a registered signal.
- Keeps a saturating count of overflowing results for status readout.

Parameters:
- DATAW, 2, operand width N; i_result is DATAW+1 bits.
- CNTW, 8, width of the overflow event counter.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst_n  input  1  synchronous reset, active-low.
- i_valid  input  1  upstream result valid.
- o_ready  output  1  stage can accept; registered.
- i_result  input  DATAW+1  signed exact sum/difference from the adder/subtractor.
- i_sat  input  1  saturate on overflow; sampled with i_result.
- o_valid  output  1  output beat valid.
- i_ready  input  1  downstream accepts.
- o_data  output  DATAW  N-bit result, wrapped or saturated.
- o_zero  output  1  o_data == 0.
- o_neg  output  1  true sign of the exact result.
- o_ovf  output  1  exact result does not fit in N signed bits.
- i_clr  input  1  clear the overflow counter.
- o_ovf_cnt  output  CNTW  count of accepted overflowing results; saturates.

Behaviour:
- Reset is synchronous, active-low: when i_rst_n=0 at a clock edge, o_valid=0, o_ready=1, o_data=0, all flags=0, o_ovf_cnt=0, and both buffer entries are invalidated. Reset mid-transfer drops all buffered beats.
- Accept on an edge where i_valid && o_ready. Transfer out on an edge where o_valid && i_ready.
- Latency: a beat accepted at edge k is presented on o_* after edge k, provided no older beat is buffered.
- Flag/data computation, applied at accept and stored per entry:
  - ovf = i_result[DATAW] ^ i_result[DATAW-1].
  - neg = i_result[DATAW].
  - If ovf && i_sat: data = neg ? 1 followed by zeros (most negative) : 0 followed by ones (most positive).
  - Otherwise: data = i_result[DATAW-1:0].
  - zero = (data == 0).
- Output o_data and all flags come from the main register only. They hold stable while o_valid && !i_ready.
- Buffer state machine:
  - EMPTY, ONE and FULL describe occupancy. o_valid = (state != EMPTY). o_ready = (state != FULL).
  - EMPTY: accept -> ONE (beat loads main).
  - ONE: accept && transfer -> ONE (main reloads). Accept && !transfer -> FULL (beat loads skid). Transfer && !accept -> EMPTY. Neither -> hold.
  - FULL: no accepts (o_ready=0). Transfer -> ONE (skid moves to main, skid is invalidated). Otherwise hold.
- Ordering is strictly FIFO. No beat is dropped or duplicated. i_valid may deassert without a transfer, and the stage requires nothing of it.
- Overflow counter:
  - Increments by 1 on each accepted beat with ovf=1, counted at accept time.
  - Saturates at 2^CNTW-1.
  - i_clr=1 forces 0 and takes priority over a coincident increment.

Test Plan:
- DATAW=4, i_ready=1. i_result=5'b00101, i_sat=0 -> next cycle o_valid=1, o_data=4'h5, o_zero=0, o_neg=0, o_ovf=0.
- 7+1 gives i_result=5'b01000. With i_sat=0 -> o_data=4'b1000, o_ovf=1, o_neg=0. With i_sat=1 -> o_data=4'b0111, o_ovf=1.
- -8-1 gives i_result=5'b10111. With i_sat=1 -> o_data=4'b1000, o_neg=1, o_ovf=1. With i_sat=0 -> o_data=4'b0111, o_ovf=1. Then i_result=5'b00000 -> o_zero=1, o_ovf=0.
- Backpressure, i_ready=0:
  - Offer beats A=1, B=2, C=3 back-to-back -> A and B accepted, o_ready=0 after B, C is held.
  - Raise i_ready -> outputs appear in order 1, 2, 3 with no gaps once flowing, and o_data holds 1 throughout the stall.
- CNTW=2: accept 5 overflowing beats -> o_ovf_cnt sequence 1, 2, 3, 3, 3. Assert i_clr together with a 6th overflowing accept -> o_ovf_cnt=0.
- FULL state with i_ready=0: assert i_rst_n=0 for one edge -> o_valid=0, o_ready=1, o_data=0, flags=0, o_ovf_cnt=0. The next accepted beat appears alone, with no stale skid data.
